// File: rtl/wrr_pkt_arb_pkg.sv
// Shared defaults for the weighted round-robin packet arbiter slice.
package wrr_pkt_arb_pkg;

  localparam int unsigned DEF_NUM_IN   = 4;
  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_WEIGHT_W = 4;

endpackage

// File: rtl/lzc.sv
// Trailing-zero counter: index of the lowest set bit, plus an empty flag.
module lzc
  import wrr_pkt_arb_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_NUM_IN,
  parameter int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] i_in,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_empty
);

  // Scan high to low so the lowest set bit is written last and wins.
  always_comb begin
    o_cnt = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (i_in[i]) o_cnt = CNT_W'(i);
    end
  end

  assign o_empty = ~|i_in;

endmodule

// File: rtl/wrr_pkt_arb_oreg.sv
// One-entry stream register holding the granted beat (payload, last, source).
module wrr_pkt_arb_oreg
  import wrr_pkt_arb_pkg::*;
#(
  parameter int unsigned DataWidth = DEF_DATA_W,
  parameter type         DataType  = logic [DataWidth-1:0],
  parameter int unsigned IdxWidth  = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                i_flush,
  input  logic                i_load,
  input  DataType             i_data,
  input  logic                i_last,
  input  logic [IdxWidth-1:0] i_idx,
  input  logic                i_gnt,
  output logic                o_vld,
  output DataType             o_data,
  output logic                o_last,
  output logic [IdxWidth-1:0] o_idx
);

  logic                r_vld;
  DataType             r_data;
  logic                r_last;
  logic [IdxWidth-1:0] r_idx;

  // Load on upstream transfer, drain on downstream grant, wipe on flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vld  <= 1'b0;
      r_data <= '0;
      r_last <= 1'b0;
      r_idx  <= '0;
    end else if (i_flush) begin
      r_vld  <= 1'b0;
      r_data <= '0;
      r_last <= 1'b0;
      r_idx  <= '0;
    end else if (i_load) begin
      r_vld  <= 1'b1;
      r_data <= i_data;
      r_last <= i_last;
      r_idx  <= i_idx;
    end else if (i_gnt) begin
      r_vld  <= 1'b0;
    end
  end

  assign o_vld  = r_vld;
  assign o_data = r_data;
  assign o_last = r_last;
  assign o_idx  = r_idx;

endmodule

// File: rtl/wrr_pkt_arb.sv
// Weighted round-robin stream arbiter: per-turn packet credit, packet lock,
// optional registered output.
module wrr_pkt_arb
  import wrr_pkt_arb_pkg::*;
#(
  parameter int unsigned NumIn       = DEF_NUM_IN,
  parameter int unsigned DataWidth   = DEF_DATA_W,
  parameter type         DataType    = logic [DataWidth-1:0],
  parameter int unsigned WeightWidth = DEF_WEIGHT_W,
  parameter bit          OutReg      = 1'b1,
  parameter int unsigned IdxWidth    = $clog2(NumIn)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                flush_i,
  input  logic [NumIn-1:0][WeightWidth-1:0]   weight_i,
  input  logic [NumIn-1:0]                    req_i,
  input  logic [NumIn-1:0]                    last_i,
  input  DataType                             data_i [NumIn],
  output logic [NumIn-1:0]                    gnt_o,
  output logic                                req_o,
  input  logic                                gnt_i,
  output DataType                             data_o,
  output logic                                last_o,
  output logic [IdxWidth-1:0]                 idx_o
);

  typedef logic [IdxWidth-1:0]    idx_t;
  typedef logic [WeightWidth-1:0] weight_t;

  idx_t    r_cur;
  weight_t r_credit;
  logic    r_lock;

  logic [NumIn-1:0] w_elig, w_upper, w_lower;
  idx_t             w_up_idx, w_lo_idx, w_win;
  logic             w_up_empty, w_lo_empty, w_any, w_active;
  logic             w_ready, w_xfer, w_win_last, w_new_turn;

  // Eligibility and the two scan windows: above the owner, then wrap to it.
  always_comb begin
    w_elig  = '0;
    w_upper = '0;
    w_lower = '0;
    for (int i = 0; i < int'(NumIn); i++) begin
      w_elig[i]  = req_i[i] & (|weight_i[i]);
      w_upper[i] = w_elig[i] & (idx_t'(i) > r_cur);
      w_lower[i] = w_elig[i] & (idx_t'(i) <= r_cur);
    end
  end

  lzc #(.WIDTH(NumIn), .CNT_W(IdxWidth)) u_lzc_up (
    .i_in    (w_upper),
    .o_cnt   (w_up_idx),
    .o_empty (w_up_empty)
  );

  lzc #(.WIDTH(NumIn), .CNT_W(IdxWidth)) u_lzc_lo (
    .i_in    (w_lower),
    .o_cnt   (w_lo_idx),
    .o_empty (w_lo_empty)
  );

  // Winner: locked owner, else owner with credit left, else next eligible.
  always_comb begin
    w_win = r_cur;
    w_any = 1'b0;
    if (r_lock) begin
      w_any = 1'b1;
    end else if (w_elig[r_cur] && (r_credit != '0)) begin
      w_any = 1'b1;
    end else if (!w_up_empty) begin
      w_win = w_up_idx;
      w_any = 1'b1;
    end else if (!w_lo_empty) begin
      w_win = w_lo_idx;
      w_any = 1'b1;
    end
  end

  // Reset and flush both mask the grant path so nothing moves that cycle.
  assign w_active   = w_any & ~flush_i & rst_ni;
  assign w_win_last = last_i[w_win];
  assign w_xfer     = w_active & req_i[w_win] & w_ready;
  assign w_new_turn = (w_win != r_cur) | (r_credit == '0);

  // Ready goes to the winner regardless of its valid (AXI-style).
  always_comb begin
    gnt_o = '0;
    if (w_active) gnt_o[w_win] = w_ready;
  end

  // Turn bookkeeping: credit is charged once per packet, on its last beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cur    <= '0;
      r_credit <= '0;
      r_lock   <= 1'b0;
    end else if (flush_i) begin
      r_cur    <= '0;
      r_credit <= '0;
      r_lock   <= 1'b0;
    end else if (w_xfer) begin
      r_lock <= ~w_win_last;
      if (w_new_turn) begin
        r_cur    <= w_win;
        r_credit <= weight_i[w_win] - weight_t'(w_win_last);
      end else begin
        r_credit <= r_credit - weight_t'(w_win_last);
      end
    end
  end

  if (OutReg) begin : g_oreg
    logic w_vld;

    wrr_pkt_arb_oreg #(
      .DataType (DataType),
      .IdxWidth (IdxWidth)
    ) u_oreg (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .i_flush (flush_i),
      .i_load  (w_xfer),
      .i_data  (data_i[w_win]),
      .i_last  (w_win_last),
      .i_idx   (w_win),
      .i_gnt   (gnt_i),
      .o_vld   (w_vld),
      .o_data  (data_o),
      .o_last  (last_o),
      .o_idx   (idx_o)
    );

    // An empty register, or one draining this cycle, can take a beat.
    assign w_ready = ~w_vld | gnt_i;
    assign req_o   = w_vld;
  end else begin : g_comb
    assign w_ready = gnt_i;
    assign req_o   = w_active & req_i[w_win];
    assign data_o  = data_i[w_win];
    assign last_o  = w_active & w_win_last;
    assign idx_o   = w_active ? w_win : '0;
  end

endmodule

// File: tb/tb_wrr_pkt_arb.sv
// Bench for wrr_pkt_arb (OutReg=1): directed scenarios plus randomized traffic
// against a turn-level reference model.
module tb_wrr_pkt_arb;

  localparam int N = 4;

  logic              clk = 1'b0;
  logic              rst_ni, flush_i, gnt_i;
  logic [N-1:0][3:0] weight_i;
  logic [N-1:0]      req_i, last_i, gnt_o;
  logic [31:0]       data_i [N];
  logic              req_o, last_o;
  logic [31:0]       data_o;
  logic [1:0]        idx_o;

  int checks = 0;
  int errors = 0;

  // Source side: each input streams packets of len beats.
  int wt[N], len[N], beat[N], seqn[N], cont_len[N];
  bit pend[N], cont[N];
  bit rst_v, flush_v, gnt_v, rnd_src;

  // Reference: current turn owner, packets left, packet in progress, out slot.
  int          m_cur, m_cr, m_idx, win;
  bit          m_lock, m_vld, m_last, xfer;
  logic [31:0] m_data;
  logic [N-1:0] exp_gnt;

  wrr_pkt_arb #(
    .NumIn(4), .DataWidth(32), .WeightWidth(4), .OutReg(1'b1)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .weight_i(weight_i),
    .req_i(req_i), .last_i(last_i), .data_i(data_i), .gnt_o(gnt_o),
    .req_o(req_o), .gnt_i(gnt_i), .data_o(data_o), .last_o(last_o),
    .idx_o(idx_o)
  );

  always #5 clk = ~clk;

  function automatic bit elig(int j);
    return pend[j] && (wt[j] != 0);
  endfunction

  function automatic bit src_last(int j);
    return beat[j] == len[j] - 1;
  endfunction

  function automatic logic [31:0] src_data(int j);
    return {8'(j), 24'(seqn[j])};
  endfunction

  // Who gets the link: the open packet's owner, the owner while its turn has
  // packets left, otherwise the next requester in circular order after it.
  function automatic int pick();
    if (m_lock) return m_cur;
    if (elig(m_cur) && m_cr > 0) return m_cur;
    for (int k = 1; k <= N; k++) begin
      if (elig((m_cur + k) % N)) return (m_cur + k) % N;
    end
    return -1;
  endfunction

  // Apply this cycle's inputs (at negedge) and predict the handshake.
  task automatic drive();
    bit ready;
    if (rnd_src) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(2) == 0) begin
          pend[i] = 1'b1;
          len[i]  = 1 + int'($urandom_range(3));
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      req_i[i]    = pend[i];
      last_i[i]   = src_last(i);
      data_i[i]   = src_data(i);
      weight_i[i] = 4'(wt[i]);
    end
    rst_ni  = rst_v;
    flush_i = flush_v;
    gnt_i   = gnt_v;
    if (!rst_v) begin
      m_cur = 0; m_cr = 0; m_lock = 1'b0; m_vld = 1'b0;
    end
    win     = pick();
    ready   = !m_vld || gnt_v;
    exp_gnt = '0;
    xfer    = 1'b0;
    if (rst_v && !flush_v && win >= 0) begin
      exp_gnt[win] = ready;
      xfer         = ready && pend[win];
    end
    #1;
  endtask

  // Advance model and sources across the clock edge.
  task automatic commit();
    bit l;
    if (xfer) begin
      l      = src_last(win);
      m_lock = !l;
      if (win != m_cur || m_cr == 0) begin
        m_cur = win;
        m_cr  = wt[win] - int'(l);
      end else begin
        m_cr = m_cr - int'(l);
      end
      m_vld  = 1'b1;
      m_data = src_data(win);
      m_last = l;
      m_idx  = win;
      seqn[win]++;
      if (l) begin
        beat[win] = 0;
        pend[win] = cont[win];
        len[win]  = cont_len[win];
      end else begin
        beat[win]++;
      end
    end else if (gnt_v) begin
      m_vld = 1'b0;
    end
    if (flush_v) begin
      m_cur = 0; m_cr = 0; m_lock = 1'b0; m_vld = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic reset_all();
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; cont[i] = 1'b0; beat[i] = 0; seqn[i] = 0;
      len[i] = 1; cont_len[i] = 1; wt[i] = 1;
    end
    rnd_src = 1'b0; flush_v = 1'b0; gnt_v = 1'b1; rst_v = 1'b0;
    drive();
    commit();
    rst_v = 1'b1;
  endtask

  task automatic test_reset();
    reset_all();
    for (int i = 0; i < N; i++) pend[i] = 1'b1;
    rst_v = 1'b0;
    drive();
    checks++; if (gnt_o !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b want 0000", gnt_o); end
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", req_o); end
    checks++; if (last_o !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", last_o); end
    checks++; if (idx_o !== 2'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", idx_o); end
    checks++; if (data_o !== 32'd0) begin errors++; $display("FAIL reset_data got %h want 0", data_o); end
    commit();
    rst_v = 1'b1;
    drive();
    checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL post_reset_req got %b want 0", req_o); end
    checks++; if (gnt_o !== 4'b0010) begin errors++; $display("FAIL post_reset_first got %b want 0010", gnt_o); end
    commit();
  endtask

  task automatic test_weighted_share();
    int pat[7] = '{1, 2, 2, 3, 0, 0, 0};
    reset_all();
    wt = '{3, 1, 2, 1};
    for (int i = 0; i < N; i++) begin cont[i] = 1'b1; pend[i] = 1'b1; end
    for (int c = 0; c < 22; c++) begin
      drive();
      checks++;
      if (c == 0) begin
        if (req_o !== 1'b0) begin errors++; $display("FAIL share_latency got %b want 0", req_o); end
      end else if (req_o !== 1'b1 || idx_o !== 2'(pat[(c-1)%7])) begin
        errors++; $display("FAIL share_seq cycle %0d got req=%b idx=%0d want req=1 idx=%0d", c, req_o, idx_o, pat[(c-1)%7]);
      end
      commit();
    end
  endtask

  task automatic test_packet_lock();
    reset_all();
    cont[0] = 1'b1; pend[0] = 1'b1;
    pend[1] = 1'b1; len[1] = 4;
    for (int c = 0; c < 6; c++) begin
      drive();
      if (c <= 3) begin
        checks++; if (gnt_o !== 4'b0010) begin errors++; $display("FAIL lock_gnt cycle %0d got %b want 0010", c, gnt_o); end
      end
      if (c == 4) begin
        checks++; if (gnt_o !== 4'b0001) begin errors++; $display("FAIL lock_release got %b want 0001", gnt_o); end
      end
      if (c >= 1 && c <= 4) begin
        checks++;
        if (req_o !== 1'b1 || idx_o !== 2'd1 || data_o !== {8'd1, 24'(c-1)} || last_o !== (c == 4)) begin
          errors++; $display("FAIL lock_beat cycle %0d got req=%b idx=%0d data=%h last=%b want 1/1/%h/%b", c, req_o, idx_o, data_o, last_o, {8'd1, 24'(c-1)}, c == 4);
        end
      end
      if (c == 5) begin
        checks++; if (req_o !== 1'b1 || idx_o !== 2'd0) begin errors++; $display("FAIL lock_next got req=%b idx=%0d want 1/0", req_o, idx_o); end
      end
      commit();
    end
  endtask

  task automatic test_disabled();
    int pat[3] = '{1, 3, 0};
    reset_all();
    wt[2] = 0;
    for (int i = 0; i < N; i++) begin cont[i] = 1'b1; pend[i] = 1'b1; end
    for (int c = 0; c < 30; c++) begin
      drive();
      checks++; if (gnt_o[2] !== 1'b0) begin errors++; $display("FAIL disabled_gnt cycle %0d got %b", c, gnt_o); end
      if (c >= 1) begin
        checks++;
        if (req_o !== 1'b1 || idx_o !== 2'(pat[(c-1)%3])) begin
          errors++; $display("FAIL disabled_rot cycle %0d got idx=%0d want %0d", c, idx_o, pat[(c-1)%3]);
        end
      end
      commit();
    end
  endtask

  task automatic test_backpressure();
    int nacc = 0;
    reset_all();
    pend[2] = 1'b1; len[2] = 8;
    for (int c = 0; c < 20; c++) begin
      gnt_v = !(c >= 3 && c <= 7);
      drive();
      if (!gnt_v) begin
        checks++;
        if (req_o !== 1'b1 || idx_o !== 2'd2 || data_o !== {8'd2, 24'd2}) begin
          errors++; $display("FAIL bp_hold cycle %0d got req=%b idx=%0d data=%h want 1/2/02000002", c, req_o, idx_o, data_o);
        end
      end else if (req_o === 1'b1) begin
        checks++;
        if (data_o !== {8'd2, 24'(nacc)} || last_o !== (nacc == 7) || c != ((nacc < 2) ? nacc + 1 : nacc + 6)) begin
          errors++; $display("FAIL bp_beat %0d cycle %0d got data=%h last=%b", nacc, c, data_o, last_o);
        end
        nacc++;
      end
      commit();
    end
    gnt_v = 1'b1;
    checks++; if (nacc != 8) begin errors++; $display("FAIL bp_count got %0d want 8", nacc); end
  endtask

  // kind 0: flush mid-packet, kind 1: reset mid-packet.
  task automatic test_flush_reset(input int kind);
    reset_all();
    for (int i = 0; i < N; i++) wt[i] = 2;
    pend[3] = 1'b1; len[3] = 6;
    for (int c = 0; c < 7; c++) begin
      if (c == 1) begin cont[0] = 1'b1; pend[0] = 1'b1; cont[1] = 1'b1; pend[1] = 1'b1; end
      flush_v = (kind == 0) && (c == 3);
      rst_v   = !((kind == 1) && (c == 3));
      drive();
      if (c <= 2) begin
        checks++; if (gnt_o !== 4'b1000) begin errors++; $display("FAIL fr%0d_locked cycle %0d got %b want 1000", kind, c, gnt_o); end
      end
      if (c == 3) begin
        checks++; if (gnt_o !== 4'b0000) begin errors++; $display("FAIL fr%0d_blocked got %b want 0000", kind, gnt_o); end
      end
      if (c == 4) begin
        checks++; if (req_o !== 1'b0) begin errors++; $display("FAIL fr%0d_req got %b want 0", kind, req_o); end
        checks++; if (gnt_o !== 4'b0010) begin errors++; $display("FAIL fr%0d_fresh got %b want 0010", kind, gnt_o); end
      end
      if (c == 5) begin
        checks++; if (req_o !== 1'b1 || idx_o !== 2'd1) begin errors++; $display("FAIL fr%0d_next got req=%b idx=%0d want 1/1", kind, req_o, idx_o); end
      end
      commit();
    end
    flush_v = 1'b0;
    rst_v   = 1'b1;
  endtask

  task automatic test_idle_wrap();
    reset_all();
    wt[3] = 2;
    cont[3] = 1'b1; pend[3] = 1'b1;
    for (int c = 0; c < 12; c++) begin
      drive();
      checks++; if (gnt_o !== 4'b1000) begin errors++; $display("FAIL wrap_gnt cycle %0d got %b want 1000", c, gnt_o); end
      if (c >= 1) begin
        checks++;
        if (req_o !== 1'b1 || idx_o !== 2'd3 || data_o !== {8'd3, 24'(c-1)}) begin
          errors++; $display("FAIL wrap_beat cycle %0d got req=%b idx=%0d data=%h", c, req_o, idx_o, data_o);
        end
      end
      commit();
    end
  endtask

  task automatic test_random();
    reset_all();
    rnd_src = 1'b1;
    for (int c = 0; c < 800; c++) begin
      if (c % 100 == 0) for (int i = 0; i < N; i++) wt[i] = int'($urandom_range(3));
      gnt_v   = ($urandom_range(3) != 0);
      flush_v = ($urandom_range(99) == 0);
      drive();
      checks++; if (gnt_o !== exp_gnt) begin errors++; $display("FAIL rnd_gnt cycle %0d got %b want %b", c, gnt_o, exp_gnt); end
      checks++; if (req_o !== m_vld) begin errors++; $display("FAIL rnd_req cycle %0d got %b want %b", c, req_o, m_vld); end
      if (m_vld) begin
        checks++;
        if (idx_o !== 2'(m_idx) || data_o !== m_data || last_o !== m_last) begin
          errors++; $display("FAIL rnd_beat cycle %0d got %0d/%h/%b want %0d/%h/%b", c, idx_o, data_o, last_o, m_idx, m_data, m_last);
        end
      end
      commit();
    end
    rnd_src = 1'b0;
    flush_v = 1'b0;
  endtask

  initial begin
    test_reset();
    test_weighted_share();
    test_packet_lock();
    test_disabled();
    test_backpressure();
    test_flush_reset(0);
    test_flush_reset(1);
    test_idle_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
